// File: rtl/m68k_mem_pkg.sv
// Shared memory-subsystem definitions: bus widths, arbiter state encodings
// and grant identifiers.
package m68k_mem_pkg;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 16;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_CPU  = 2'd1,
      ARB_DMA  = 2'd2,
      ARB_TURN = 2'd3
   } arb_state_e;

   localparam logic GNT_CPU = 1'b0;
   localparam logic GNT_DMA = 1'b1;
endpackage

// File: rtl/m68k_arb_hold_counter.sv
// Counts completed DMA accesses (address-strobe rising edges) and saturates
// at MAX. The arbiter uses the max flag to decide when the CPU may preempt.
module m68k_arb_hold_counter #(
   parameter int  MAX = 16,
   localparam int CW  = $clog2(MAX + 1)
) (
   input  logic          Clock,
   input  logic          Reset_L,
   input  logic          en_i,
   input  logic          clr_i,
   input  logic          as_l_i,
   output logic [CW-1:0] count_o,
   output logic          max_o
);
   logic          as_d_q;
   logic [CW-1:0] count_q, count_d;
   logic          rise;

   // An access ends when AS_L returns high.
   assign rise = en_i && !as_d_q && as_l_i;

   always_comb begin
      count_d = count_q;
      if (clr_i)
         count_d = '0;
      else if (rise && (count_q != CW'(MAX)))
         count_d = count_q + 1'b1;
   end

   always_ff @(posedge Clock or negedge Reset_L) begin
      if (!Reset_L) begin
         as_d_q  <= 1'b1;
         count_q <= '0;
      end else begin
         as_d_q  <= as_l_i;
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign max_o   = (count_q == CW'(MAX));
endmodule

// File: rtl/m68k_dram_arbiter.sv
// Round-robin arbiter sharing the DRAM controller between the cache controller
// and the DMA engine, with a turnaround gap and bounded DMA burst length.
module m68k_dram_arbiter
   import m68k_mem_pkg::*;
#(
   parameter int DMA_BURST_MAX = 16,
   parameter int TURNAROUND    = 1
) (
   input  logic              Clock,
   input  logic              Reset_L,
   input  logic              CpuSelect_L,
   input  logic              CpuAS_L,
   input  logic              CpuWE_L,
   input  logic              CpuUDS_L,
   input  logic              CpuLDS_L,
   input  logic [ADDR_W-1:0] CpuAddress,
   input  logic [DATA_W-1:0] CpuDataOut,
   output logic              CpuDtack_L,
   input  logic              DmaReq_H,
   output logic              DmaGnt_H,
   input  logic              DmaAS_L,
   input  logic              DmaWE_L,
   input  logic              DmaUDS_L,
   input  logic              DmaLDS_L,
   input  logic [ADDR_W-1:0] DmaAddress,
   input  logic [DATA_W-1:0] DmaDataOut,
   output logic              DmaDtack_L,
   output logic              DramSelect_L,
   output logic              DramAS_L,
   output logic              DramWE_L,
   output logic              DramUDS_L,
   output logic              DramLDS_L,
   output logic [ADDR_W-1:0] DramAddress,
   output logic [DATA_W-1:0] DramDataOut,
   input  logic              DtackFromDram_L,
   output logic [1:0]        ArbState
);
   localparam int HCW = $clog2(DMA_BURST_MAX + 1);

   arb_state_e     state_q;
   logic           last_grant_q;
   logic [2:0]     turn_cnt_q;
   logic [HCW-1:0] hold_count;
   logic           hold_max;
   logic           cpu_req;
   logic           dma_exit;

   assign cpu_req = !CpuSelect_L;

   // Release only between accesses: never while DmaAS_L is low.
   assign dma_exit = (state_q == ARB_DMA) && DmaAS_L &&
                     (!DmaReq_H || (hold_max && cpu_req));

   m68k_arb_hold_counter #(.MAX(DMA_BURST_MAX)) u_hold (
      .Clock   (Clock),
      .Reset_L (Reset_L),
      .en_i    (state_q == ARB_DMA),
      .clr_i   ((state_q != ARB_DMA) || dma_exit),
      .as_l_i  (DmaAS_L),
      .count_o (hold_count),
      .max_o   (hold_max)
   );

   always_ff @(posedge Clock or negedge Reset_L) begin
      if (!Reset_L) begin
         state_q      <= ARB_IDLE;
         last_grant_q <= GNT_DMA;
         turn_cnt_q   <= '0;
      end else begin
         case (state_q)
            ARB_IDLE:
               if (cpu_req && (!DmaReq_H || (last_grant_q == GNT_DMA)))
                  state_q <= ARB_CPU;
               else if (DmaReq_H)
                  state_q <= ARB_DMA;
            ARB_CPU:
               if (CpuSelect_L) begin
                  last_grant_q <= GNT_CPU;
                  state_q      <= ARB_TURN;
               end
            ARB_DMA:
               if (dma_exit) begin
                  last_grant_q <= GNT_DMA;
                  state_q      <= ARB_TURN;
               end
            default:
               if (turn_cnt_q == 3'(TURNAROUND - 1)) begin
                  turn_cnt_q <= '0;
                  state_q    <= ARB_IDLE;
               end else begin
                  turn_cnt_q <= turn_cnt_q + 3'd1;
               end
         endcase
      end
   end

   // Muxing decodes only the registered state, so reset deactivates outputs at once.
   always_comb begin
      DramSelect_L = 1'b1;
      DramAS_L     = 1'b1;
      DramWE_L     = 1'b1;
      DramUDS_L    = 1'b1;
      DramLDS_L    = 1'b1;
      DramAddress  = '0;
      DramDataOut  = '0;
      CpuDtack_L   = 1'b1;
      DmaDtack_L   = 1'b1;
      DmaGnt_H     = 1'b0;
      case (state_q)
         ARB_CPU: begin
            DramSelect_L = CpuSelect_L;
            DramAS_L     = CpuAS_L;
            DramWE_L     = CpuWE_L;
            DramUDS_L    = CpuUDS_L;
            DramLDS_L    = CpuLDS_L;
            DramAddress  = CpuAddress;
            DramDataOut  = CpuDataOut;
            CpuDtack_L   = DtackFromDram_L;
         end
         ARB_DMA: begin
            DmaGnt_H     = 1'b1;
            DramSelect_L = DmaAS_L;
            DramAS_L     = DmaAS_L;
            DramWE_L     = DmaWE_L;
            DramUDS_L    = DmaUDS_L;
            DramLDS_L    = DmaLDS_L;
            DramAddress  = DmaAddress;
            DramDataOut  = DmaDataOut;
            DmaDtack_L   = DtackFromDram_L;
         end
         default: ;
      endcase
   end

   assign ArbState = state_q;
endmodule
